prism_prog_loader: RTL and testbench
====================================

# prism_prog_loader

Program-load sequencer for the PRISM controller's debug write port. It buffers configuration words from the host in a small FIFO. On command it halts and resets the PRISM engine, then streams the buffered words into consecutive debug addresses, one per cycle. Finally it releases the engine with a host-chosen enable state. It sits between the TinyQV register decode and the PRISM debug port, and gives the CPU muxed direct access whenever no load is in progress.

## Interface
- `FIFO_DEPTH`, 4: word buffer depth; a power of two, minimum 2.
- `TIMEOUT`, 255: idle cycles allowed in LOAD with an empty FIFO before abort; range 1–255.
- `clk` in 1: project clock.
- `rst_n` in 1: asynchronous active-low reset.
- `push` in 1: enqueue `push_data` this cycle.
- `push_data` in 32: configuration word.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` words.
- `start` in 1: begin load (pulse).
- `base_addr` in 6: first debug address, sampled on accepted `start`.
- `word_count` in 6: number of words to write (0–63), sampled on accepted `start`.
- `run_after` in 1: `prism_enable` value applied at release, sampled on accepted `start`.
- `abort` in 1: terminate load (pulse).
- `cpu_wr` in 1: direct CPU debug write request.
- `cpu_addr` in 6: CPU debug address.
- `cpu_wdata` in 32: CPU debug write data.
- `cpu_reset` in 1: CPU-requested PRISM reset level.
- `cpu_enable` in 1: CPU-requested PRISM enable level.
- `dbg_wr` out 1: PRISM debug write strobe.
- `dbg_addr` out 6: PRISM debug address.
- `dbg_wdata` out 32: PRISM debug write data.
- `prism_reset` out 1: PRISM debug reset.
- `prism_enable` out 1: PRISM FSM enable.
- `busy` out 1: FSM is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `status` out 3: sticky error flags {timeout, cpu_collision, overflow}; cleared on accepted `start`.

## Operation
- FSM states: IDLE, HALT, LOAD, RELEASE.
- IDLE:
  - `dbg_*`, `prism_reset` and `prism_enable` pass through from the `cpu_*` inputs combinationally.
  - `start` → HALT and latch parameters.
- HALT: one cycle with `prism_reset`=1, `prism_enable`=0, `dbg_wr`=0. Next state is LOAD, or RELEASE if `word_count`=0.
- LOAD, while `prism_reset`=1 and `prism_enable`=0:
  - Each cycle with the FIFO non-empty: pop the head word, drive `dbg_wr`=1, `dbg_addr`=current address, `dbg_wdata`=head word.
  - After each write, increment the address (6-bit wrap, 63→0) and decrement the remaining count.
  - When the last word has been written → RELEASE.
  - FIFO empty: no write; the idle counter increments. The idle counter clears on each write.
  - Idle counter reaches `TIMEOUT` → set `status[2]` → RELEASE with enable forced to 0.
- RELEASE: one cycle with `prism_reset`=0, `prism_enable`=latched `run_after` (0 after abort or timeout). Assert `done`, then go to IDLE.
- After leaving RELEASE, control passes back to the CPU inputs. The CPU must program `cpu_enable` before issuing `start` to keep the engine running.
- FIFO:
  - `push` while full drops the word and sets `status[0]`.
  - Simultaneous push and pop while full is accepted, since the pop frees the slot.
  - Push is allowed in any state.
- `cpu_wr` while busy is ignored, never forwarded, and sets `status[1]`.
- `abort` while busy:
  - Flush the FIFO and go next cycle to RELEASE with enable=0.
  - `done` still pulses.
  - `abort` in IDLE flushes the FIFO only.
- `start` while busy is ignored. `start` and `abort` in the same cycle: `abort` wins and `start` is ignored.
- Words left in the FIFO after `word_count` words have been written stay queued for the next load.

## Timing
- Reset values: FSM=IDLE, FIFO empty, `fifo_full`=0, `busy`=0, `done`=0, `status`=0, internal counters 0. `dbg_*`, `prism_reset` and `prism_enable` follow the `cpu_*` inputs.
- Sequence from `start` at cycle 0:
  - Cycle 1: HALT.
  - Cycle 2: first write, if the FIFO is non-empty.
  - With the FIFO pre-filled and N≥1 words: writes occur in cycles 2..N+1, RELEASE/`done` in cycle N+2, IDLE in cycle N+3.
- A push in cycle k can be written no earlier than cycle k+1; there is no bypass.
- Outputs in HALT, LOAD and RELEASE are registered. Only the IDLE pass-through is combinational.
- `rst_n` asserted mid-load returns everything to reset values immediately; the partial write sequence is abandoned.

## Structure
- `prism_loader_pkg`: state enum (IDLE/HALT/LOAD/RELEASE) and `status` bit index constants.
- One sub-module, `prism_loader_fifo`:
  - Parameterised 32-bit synchronous FIFO.
  - Ports: `push`, `pop`, `flush`, `full`, `empty`, head data.
  - Pointers one bit wider than the address, for full/empty detection.

## Test plan
- Nominal load:
  - Push 3 words, `start` with base=0x10, count=3, run_after=1.
  - Expect writes to 0x10, 0x11, 0x12 in cycles 2–4.
  - Cycle 5: `done`=1, `prism_enable`=1, `prism_reset`=0.
- Address wrap and starvation:
  - base=0x3F, count=2, one word pushed first and the second pushed 5 cycles later.
  - Expect writes to 0x3F then 0x00; no timeout.
- Timeout:
  - `TIMEOUT`=4, count=2, FIFO empty.
  - Expect `status[2]`=1 and RELEASE 4 idle cycles after HALT.
  - Expect `prism_enable`=0 and `done` pulse.
- Overflow: `FIFO_DEPTH`=4, push 5 words in IDLE → `fifo_full`=1, `status[0]`=1, only the first 4 words are written.
- Collision and abort:
  - `cpu_wr` during LOAD → `dbg_wr` carries only loader writes and `status[1]`=1.
  - `abort` mid-load → FIFO empty, enable=0, `done` pulses.
- Async reset mid-LOAD → `busy`=0 and FIFO empty at once; `dbg_wr` follows `cpu_wr`.

Source files
------------

// File: rtl/prism_prog_loader_pkg.sv
// Shared types and constants for the PRISM program loader.
package prism_loader_pkg;

  // Sequencer states: idle pass-through, engine halt, word streaming, engine release.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HALT    = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RELEASE = 2'd3
  } loader_state_t;

  // Bit positions inside the sticky status vector.
  localparam int STATUS_OVERFLOW  = 0;
  localparam int STATUS_COLLISION = 1;
  localparam int STATUS_TIMEOUT   = 2;

  localparam int DBG_ADDR_W = 6;
  localparam int DATA_W     = 32;

  // Debug addresses wrap modulo 64, so the last slot is followed by slot 0.
  function automatic logic [DBG_ADDR_W-1:0] nextDbgAddr(input logic [DBG_ADDR_W-1:0] addr);
    return addr + 6'd1;
  endfunction

endpackage

// File: rtl/prism_prog_loader_if.sv
// Host/CPU/debug-port signal bundle of the PRISM program loader.
interface prism_prog_loader_if;

  logic        push;
  logic [31:0] push_data;
  logic        fifo_full;
  logic        start;
  logic [5:0]  base_addr;
  logic [5:0]  word_count;
  logic        run_after;
  logic        abort;
  logic        cpu_wr;
  logic [5:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_reset;
  logic        cpu_enable;
  logic        dbg_wr;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        prism_reset;
  logic        prism_enable;
  logic        busy;
  logic        done;
  logic [2:0]  status;

  // Register-decode side: issues words, commands and direct CPU accesses.
  modport master (
    output push, push_data, start, base_addr, word_count, run_after, abort,
           cpu_wr, cpu_addr, cpu_wdata, cpu_reset, cpu_enable,
    input  fifo_full, dbg_wr, dbg_addr, dbg_wdata, prism_reset, prism_enable,
           busy, done, status
  );

  // Loader side: consumes commands and drives the PRISM debug port.
  modport slave (
    input  push, push_data, start, base_addr, word_count, run_after, abort,
           cpu_wr, cpu_addr, cpu_wdata, cpu_reset, cpu_enable,
    output fifo_full, dbg_wr, dbg_addr, dbg_wdata, prism_reset, prism_enable,
           busy, done, status
  );

endinterface

// File: rtl/prism_prog_loader_fifo.sv
// Small word FIFO buffering configuration words ahead of a load.
module prism_loader_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic [31:0] i_push_data,
  input  logic        i_pop,
  input  logic        i_flush,
  output logic        o_full,
  output logic        o_empty,
  output logic [31:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [31:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  // The extra pointer bit distinguishes a full ring from an empty one.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push against a full ring still lands.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; a flush discards everything queued before this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/prism_prog_loader.sv
// Program-load sequencer: halts PRISM, streams buffered words into its debug port, releases it.
module prism_prog_loader
  import prism_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  prism_prog_loader_if.slave bus
);

  loader_state_t r_state;
  loader_state_t w_next_state;

  logic [5:0]  r_addr;
  logic [5:0]  r_remaining;
  logic        r_run_after;
  logic [7:0]  r_idle_cnt;
  logic [2:0]  r_status;

  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;
  logic        w_pop;
  logic        w_start_acc;
  logic        w_abort_busy;
  logic        w_timeout;
  logic        w_last_write;
  logic        w_overflow;
  logic        w_collision;
  logic [8:0]  w_idle_plus;
  logic [2:0]  w_status_set;

  logic        w_dbg_wr;
  logic [5:0]  w_dbg_addr;
  logic [31:0] w_dbg_wdata;
  logic        w_prism_reset;
  logic        w_prism_enable;

  prism_loader_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (bus.push),
    .i_push_data (bus.push_data),
    .i_pop       (w_pop),
    .i_flush     (bus.abort),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  // Abort beats start; abort during RELEASE only flushes since the engine is already going out.
  assign w_start_acc  = (r_state == ST_IDLE) && bus.start && !bus.abort;
  assign w_abort_busy = bus.abort && ((r_state == ST_HALT) || (r_state == ST_LOAD));

  // The remaining count is never zero inside LOAD, so a non-empty FIFO always means a write.
  assign w_pop        = (r_state == ST_LOAD) && !w_empty && (r_remaining != 6'd0);
  assign w_last_write = w_pop && (r_remaining == 6'd1);
  assign w_idle_plus  = {1'b0, r_idle_cnt} + 9'd1;
  assign w_timeout    = (r_state == ST_LOAD) && w_empty && (w_idle_plus >= 9'(TIMEOUT));

  assign w_overflow   = bus.push && w_full && !w_pop;
  assign w_collision  = bus.cpu_wr && (r_state != ST_IDLE);

  // Collect this cycle's error events into their status bit positions.
  always_comb begin
    w_status_set                   = '0;
    w_status_set[STATUS_OVERFLOW]  = w_overflow;
    w_status_set[STATUS_COLLISION] = w_collision;
    w_status_set[STATUS_TIMEOUT]   = w_timeout;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection and debug-port drive; only IDLE forwards the CPU request.
  always_comb begin
    w_next_state   = r_state;
    w_dbg_wr       = 1'b0;
    w_dbg_addr     = r_addr;
    w_dbg_wdata    = '0;
    w_prism_reset  = 1'b1;
    w_prism_enable = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_dbg_wr       = bus.cpu_wr;
        w_dbg_addr     = bus.cpu_addr;
        w_dbg_wdata    = bus.cpu_wdata;
        w_prism_reset  = bus.cpu_reset;
        w_prism_enable = bus.cpu_enable;
        if (w_start_acc) begin
          w_next_state = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.abort || (r_remaining == 6'd0)) begin
          w_next_state = ST_RELEASE;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_dbg_wr    = w_pop;
        w_dbg_wdata = w_pop ? w_head : 32'd0;
        if (bus.abort || w_last_write || w_timeout) begin
          w_next_state = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_prism_reset  = 1'b0;
        w_prism_enable = r_run_after;
        w_next_state   = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Load parameters, address/count walk, starvation counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_run_after <= 1'b0;
      r_idle_cnt  <= '0;
      r_status    <= '0;
    end else begin
      r_status <= (w_start_acc ? 3'b000 : r_status) | w_status_set;
      if (w_start_acc) begin
        r_addr      <= bus.base_addr;
        r_remaining <= bus.word_count;
        r_run_after <= bus.run_after;
        r_idle_cnt  <= '0;
      end else begin
        if (w_abort_busy || w_timeout) begin
          r_run_after <= 1'b0;
        end
        if (w_pop) begin
          r_addr      <= nextDbgAddr(r_addr);
          r_remaining <= r_remaining - 6'd1;
          r_idle_cnt  <= '0;
        end else if ((r_state == ST_LOAD) && w_empty) begin
          r_idle_cnt  <= w_idle_plus[7:0];
        end
      end
    end
  end

  assign bus.fifo_full    = w_full;
  assign bus.dbg_wr       = w_dbg_wr;
  assign bus.dbg_addr     = w_dbg_addr;
  assign bus.dbg_wdata    = w_dbg_wdata;
  assign bus.prism_reset  = w_prism_reset;
  assign bus.prism_enable = w_prism_enable;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.done         = (r_state == ST_RELEASE);
  assign bus.status       = r_status;

endmodule

// File: tb/tb_prism_prog_loader.sv
// Directed bench for the PRISM program loader (FIFO depth 4, starvation limit 4 cycles).
module tb_prism_prog_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   testsRun    = 0;
  int   testsFailed = 0;

  prism_prog_loader_if bus();

  prism_prog_loader #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Hard stop so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pushEn, input logic [31:0] pushData,
                               input logic startEn, input logic abortEn);
    bus.push      = pushEn;
    bus.push_data = pushData;
    bus.start     = startEn;
    bus.abort     = abortEn;
  endtask

  task automatic setLoad(input logic [5:0] base, input logic [5:0] count, input logic runAfter);
    bus.base_addr  = base;
    bus.word_count = count;
    bus.run_after  = runAfter;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleCycle();
    @(negedge clk);
  endtask

  logic [31:0] nomWords [3];
  logic [31:0] ovfWords [5];
  logic [31:0] ovfExpect[5];

  initial begin
    nomWords  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    ovfWords  = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003, 32'hA4A4_0004};
    ovfExpect = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003, 32'h5555_5555};

    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    setLoad(6'd0, 6'd0, 1'b0);
    bus.cpu_wr     = 1'b0;
    bus.cpu_addr   = 6'd0;
    bus.cpu_wdata  = 32'd0;
    bus.cpu_reset  = 1'b0;
    bus.cpu_enable = 1'b0;

    // ---- reset values and IDLE pass-through ----
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_busy",   bus.busy,      32'd0);
    checkOutput("reset_done",   bus.done,      32'd0);
    checkOutput("reset_status", bus.status,    32'd0);
    checkOutput("reset_full",   bus.fifo_full, 32'd0);
    bus.cpu_wr     = 1'b1;
    bus.cpu_addr   = 6'h05;
    bus.cpu_wdata  = 32'hDEAD_BEEF;
    bus.cpu_reset  = 1'b1;
    bus.cpu_enable = 1'b1;
    #1;
    checkOutput("pass_wr",     bus.dbg_wr,       32'd1);
    checkOutput("pass_addr",   bus.dbg_addr,     32'h05);
    checkOutput("pass_wdata",  bus.dbg_wdata,    32'hDEAD_BEEF);
    checkOutput("pass_reset",  bus.prism_reset,  32'd1);
    checkOutput("pass_enable", bus.prism_enable, 32'd1);
    bus.cpu_wr     = 1'b0;
    bus.cpu_reset  = 1'b0;
    bus.cpu_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();

    // ---- nominal load: 3 words to 0x10..0x12, run afterwards ----
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, nomWords[i], 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    setLoad(6'h10, 6'd3, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("nom_halt_busy",   bus.busy,         32'd1);
    checkOutput("nom_halt_reset",  bus.prism_reset,  32'd1);
    checkOutput("nom_halt_enable", bus.prism_enable, 32'd0);
    checkOutput("nom_halt_wr",     bus.dbg_wr,       32'd0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      sampleCycle();
      checkOutput($sformatf("nom_wr%0d", i),    bus.dbg_wr,    32'd1);
      checkOutput($sformatf("nom_addr%0d", i),  bus.dbg_addr,  32'h10 + i);
      checkOutput($sformatf("nom_wdata%0d", i), bus.dbg_wdata, nomWords[i]);
    end
    nextCycle();
    sampleCycle();
    checkOutput("nom_done",   bus.done,         32'd1);
    checkOutput("nom_enable", bus.prism_enable, 32'd1);
    checkOutput("nom_reset",  bus.prism_reset,  32'd0);
    checkOutput("nom_rel_wr", bus.dbg_wr,       32'd0);
    nextCycle();
    sampleCycle();
    checkOutput("nom_idle_busy", bus.busy, 32'd0);
    checkOutput("nom_idle_done", bus.done, 32'd0);

    // ---- address wrap 0x3F -> 0x00 with a starved second word ----
    applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    setLoad(6'h3F, 6'd2, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    nextCycle();
    sampleCycle();
    checkOutput("wrap_wr0",    bus.dbg_wr,    32'd1);
    checkOutput("wrap_addr0",  bus.dbg_addr,  32'h3F);
    checkOutput("wrap_wdata0", bus.dbg_wdata, 32'hAAAA_0001);
    nextCycle();
    sampleCycle();
    checkOutput("wrap_starve_c3", bus.dbg_wr, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("wrap_no_bypass", bus.dbg_wr, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("wrap_wr1",    bus.dbg_wr,    32'd1);
    checkOutput("wrap_addr1",  bus.dbg_addr,  32'h00);
    checkOutput("wrap_wdata1", bus.dbg_wdata, 32'hBBBB_0002);
    nextCycle();
    sampleCycle();
    checkOutput("wrap_done",   bus.done,         32'd1);
    checkOutput("wrap_status", bus.status,       32'd0);
    checkOutput("wrap_enable", bus.prism_enable, 32'd0);
    nextCycle();
    sampleCycle();
    checkOutput("wrap_idle_busy", bus.busy, 32'd0);

    // ---- timeout: 2 words requested, FIFO empty ----
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    setLoad(6'h00, 6'd2, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      nextCycle();
      sampleCycle();
      checkOutput($sformatf("tmo_idle_wr_c%0d", k),     bus.dbg_wr, 32'd0);
      checkOutput($sformatf("tmo_idle_status_c%0d", k), bus.status, 32'd0);
    end
    nextCycle();
    sampleCycle();
    checkOutput("tmo_done",   bus.done,         32'd1);
    checkOutput("tmo_status", bus.status,       32'b100);
    checkOutput("tmo_enable", bus.prism_enable, 32'd0);
    checkOutput("tmo_reset",  bus.prism_reset,  32'd0);
    nextCycle();
    sampleCycle();
    checkOutput("tmo_idle_busy",     bus.busy,   32'd0);
    checkOutput("tmo_status_sticky", bus.status, 32'b100);

    // ---- overflow: 5 pushes into a 4-deep FIFO, then push-with-pop while full ----
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, ovfWords[i], 1'b0, 1'b0);
      if (i == 4) begin
        sampleCycle();
        checkOutput("ovf_full_before_5th", bus.fifo_full, 32'd1);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("ovf_full",   bus.fifo_full, 32'd1);
    checkOutput("ovf_status", bus.status,    32'b101);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    setLoad(6'h20, 6'd5, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("ovf_status_cleared", bus.status,    32'd0);
    checkOutput("ovf_halt_full",      bus.fifo_full, 32'd1);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      if (i == 0) begin
        applyStimulus(1'b1, 32'h5555_5555, 1'b0, 1'b0);
      end else begin
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
      end
      sampleCycle();
      checkOutput($sformatf("ovf_wr%0d", i),    bus.dbg_wr,    32'd1);
      checkOutput($sformatf("ovf_addr%0d", i),  bus.dbg_addr,  32'h20 + i);
      checkOutput($sformatf("ovf_wdata%0d", i), bus.dbg_wdata, ovfExpect[i]);
    end
    nextCycle();
    sampleCycle();
    checkOutput("ovf_done",       bus.done,         32'd1);
    checkOutput("ovf_enable",     bus.prism_enable, 32'd1);
    checkOutput("ovf_status_end", bus.status,       32'd0);
    nextCycle();

    // ---- CPU collision during a load, then abort mid-load ----
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    setLoad(6'h08, 6'd6, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = 6'h03;
    bus.cpu_wdata = 32'hBAD0_BAD0;
    sampleCycle();
    checkOutput("col_halt_wr", bus.dbg_wr, 32'd0);
    nextCycle();
    sampleCycle();
    checkOutput("col_wr",    bus.dbg_wr,    32'd1);
    checkOutput("col_addr",  bus.dbg_addr,  32'h08);
    checkOutput("col_wdata", bus.dbg_wdata, 32'hC000_0000);
    nextCycle();
    bus.cpu_wr = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    sampleCycle();
    checkOutput("col_status", bus.status,    32'b010);
    checkOutput("abt_addr",   bus.dbg_addr,  32'h09);
    checkOutput("abt_wdata",  bus.dbg_wdata, 32'hC000_0001);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("abt_done",   bus.done,         32'd1);
    checkOutput("abt_enable", bus.prism_enable, 32'd0);
    checkOutput("abt_reset",  bus.prism_reset,  32'd0);
    nextCycle();
    sampleCycle();
    checkOutput("abt_idle_busy", bus.busy, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hD000_0000 + i, 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b1, 32'hD000_0003, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("abt_flushed_3", bus.fifo_full, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("abt_flushed_4", bus.fifo_full, 32'd1);

    // ---- asynchronous reset in the middle of a load ----
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    setLoad(6'h00, 6'd4, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    nextCycle();
    sampleCycle();
    checkOutput("rst_pre_wdata", bus.dbg_wdata, 32'hD000_0000);
    nextCycle();
    #2;
    rst_n          = 1'b0;
    bus.cpu_wr     = 1'b1;
    bus.cpu_addr   = 6'h2A;
    bus.cpu_wdata  = 32'h1234_5678;
    bus.cpu_enable = 1'b1;
    #1;
    checkOutput("rst_busy",   bus.busy,         32'd0);
    checkOutput("rst_done",   bus.done,         32'd0);
    checkOutput("rst_status", bus.status,       32'd0);
    checkOutput("rst_wr",     bus.dbg_wr,       32'd1);
    checkOutput("rst_addr",   bus.dbg_addr,     32'h2A);
    checkOutput("rst_enable", bus.prism_enable, 32'd1);
    checkOutput("rst_reset",  bus.prism_reset,  32'd0);
    bus.cpu_wr     = 1'b0;
    bus.cpu_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 32'hE000_0000, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("rst_fifo_empty", bus.fifo_full, 32'd0);
    for (int i = 1; i < 4; i++) begin
      nextCycle();
      applyStimulus(1'b1, 32'hE000_0000 + i, 1'b0, 1'b0);
    end
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("rst_refill_full", bus.fifo_full, 32'd1);

    // ---- start and abort together in IDLE: abort flushes, start is ignored ----
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    setLoad(6'h00, 6'd1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("sa_busy",  bus.busy,      32'd0);
    checkOutput("sa_flush", bus.fifo_full, 32'd0);

    // ---- zero word count: HALT goes straight to RELEASE ----
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    setLoad(6'h00, 6'd0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    sampleCycle();
    checkOutput("zc_halt_busy", bus.busy, 32'd1);
    nextCycle();
    sampleCycle();
    checkOutput("zc_done",   bus.done,         32'd1);
    checkOutput("zc_enable", bus.prism_enable, 32'd1);
    checkOutput("zc_wr",     bus.dbg_wr,       32'd0);
    nextCycle();
    sampleCycle();
    checkOutput("zc_idle_busy", bus.busy, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
